// File: rtl/dram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and
// default address/data widths.
package dram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  // IDLE arbitrates between requesters; OWNn keeps requester n in control.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Index of a granted requester from a one-hot grant vector.
  function automatic logic gnt_idx(input logic [1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/dram_arb_pick.sv
// Two-way combinational picker: on contention the favoured requester wins,
// otherwise the only requester present wins. Grant is one-hot or zero.
module dram_arb_pick (
  input  logic [1:0] req,
  input  logic       fav,
  output logic [1:0] gnt
);

  // Resolve the request pair into a one-hot grant.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = fav ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dram_arb.sv
// Arbiter sharing one simple dual-port RAM between two requesters.
// Grants are combinational and the access issues in the grant cycle; read
// data returns one cycle later straight from ram_dout with a per-requester
// rvalid. A requester may lock ownership across consecutive grants.
// Build option: DRAM_ARB_RR_EN selects round-robin IDLE arbitration using a
// last-grant register; when undefined, requester 0 has fixed priority.
module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_t  state;
  logic [1:0]  pick_gnt;
  logic [1:0]  gnt;
  logic        fav;
  logic        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DRAM_ARB_RR_EN
  // Index of the most recently granted requester; reset favours requester 0.
  logic last_gnt;

  assign fav = ~last_gnt;

  // Track the last grant on every granted cycle, owned or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_gnt <= gnt_idx(gnt);
    end
  end
`else
  assign fav = 1'b0;
`endif

  dram_arb_pick u_pick (
    .req (({req1, req0})),
    .fav (fav),
    .gnt (pick_gnt)
  );

  // Grant selection: picker in IDLE, owner only while locked; none in reset.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      unique case (state)
        IDLE:    gnt = pick_gnt;
        OWN0:    gnt = {1'b0, req0};
        OWN1:    gnt = {req1, 1'b0};
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Mux the granted requester's command fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[0]) begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end else if (gnt[1]) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Drive the RAM ports; unused fields are held at zero.
  always_comb begin
    ram_w_en   = 1'b0;
    ram_r_en   = 1'b0;
    ram_w_addr = '0;
    ram_r_addr = '0;
    ram_din    = '0;
    if (gnt != 2'b00) begin
      if (sel_we) begin
        ram_w_en   = 1'b1;
        ram_w_addr = sel_addr;
        ram_din    = sel_wdata;
      end else begin
        ram_r_en   = 1'b1;
        ram_r_addr = sel_addr;
      end
    end
  end

  assign rdata = ram_dout;

  // Ownership FSM plus registered read-valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt[0] & ~we0;
      rvalid1 <= gnt[1] & ~we1;
      unique case (state)
        IDLE: begin
          if (gnt[0] && lock0) begin
            state <= OWN0;
          end else if (gnt[1] && lock1) begin
            state <= OWN1;
          end
        end
        // While owned, a present request is always granted, so dropping
        // either req or lock releases ownership.
        OWN0: begin
          if (!req0 || !lock0) begin
            state <= IDLE;
          end
        end
        OWN1: begin
          if (!req1 || !lock1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arb.sv
// Bench for dram_arb: directed vector table, hand-written reset corner cases
// and randomized traffic against a behavioural model with its own memory.
module tb_dram_arb;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_w_en, ram_r_en;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_din, ram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .lock0      (lock0),
    .lock1      (lock1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata      (rdata),
    .ram_w_en   (ram_w_en),
    .ram_w_addr (ram_w_addr),
    .ram_din    (ram_din),
    .ram_r_en   (ram_r_en),
    .ram_r_addr (ram_r_addr),
    .ram_dout   (ram_dout)
  );

  // SoC-side RAM: registered read, one cycle latency.
  logic [DW-1:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_w_en) ram[ram_w_addr] <= ram_din;
    if (ram_r_en) ram_dout <= ram[ram_r_addr];
  end

  // ---------------- reference model ----------------
  int            m_owner = -1;   // -1 none, else owning requester
  int            m_last  = 1;    // last granted requester
  bit            m_rv0, m_rv1;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [256];

  function automatic int m_pick();
    if (m_owner == 0) return req0 ? 0 : -1;
    if (m_owner == 1) return req1 ? 1 : -1;
    if (req0 && req1) begin
`ifdef DRAM_ARB_RR_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1;
    m_last  = 1;
    m_rv0   = 1'b0;
    m_rv1   = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit r0, input bit w0, input bit l0, input logic [7:0] a0,
                        input logic [7:0] d0, input bit r1, input bit w1, input bit l1,
                        input logic [7:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  // Called just after a negedge with inputs applied: check against the model,
  // advance one clock, update the model, return at the next negedge.
  task automatic cycle();
    int            g;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    g = m_pick();
    w = (g == 0) ? we0 : we1;
    a = (g == 0) ? addr0 : addr1;
    d = (g == 0) ? wdata0 : wdata1;
    chk("gnt0", gnt0, (g == 0));
    chk("gnt1", gnt1, (g == 1));
    if (g < 0) begin
      chk("idle_w_en", ram_w_en, 0);
      chk("idle_r_en", ram_r_en, 0);
      chk("idle_w_addr", ram_w_addr, 0);
      chk("idle_r_addr", ram_r_addr, 0);
      chk("idle_din", ram_din, 0);
    end else begin
      chk("ram_w_en", ram_w_en, w);
      chk("ram_r_en", ram_r_en, !w);
      if (w) begin
        chk("ram_w_addr", ram_w_addr, a);
        chk("ram_din", ram_din, d);
      end else begin
        chk("ram_r_addr", ram_r_addr, a);
      end
    end
    chk("rvalid0", rvalid0, m_rv0);
    chk("rvalid1", rvalid1, m_rv1);
    if (m_rv0 || m_rv1) chk("rdata", rdata, m_rdata);
    @(posedge clk);
    m_rv0 = (g == 0) && !w;
    m_rv1 = (g == 1) && !w;
    if (g >= 0) begin
      if (w) m_mem[a] = d;
      else   m_rdata = m_mem[a];
      m_last = g;
    end
    m_owner = (g >= 0 && ((g == 0) ? lock0 : lock1)) ? g : -1;
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         r0, w0, l0;
    logic [7:0] a0, d0;
    bit         r1, w1, l1;
    logic [7:0] a1, d1;
    logic [1:0] gnt;   // {gnt1, gnt0}
    logic [1:0] rv;    // {rvalid1, rvalid0}
    logic [7:0] rd;    // checked only when rv != 0
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input bit r0, input bit w0, input bit l0, input logic [7:0] a0,
                              input logic [7:0] d0, input bit r1, input bit w1, input bit l1,
                              input logic [7:0] a1, input logic [7:0] d1,
                              input logic [1:0] g, input logic [1:0] rv, input logic [7:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.gnt = g; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  initial begin
    logic [7:0] ra, rd0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    set_in(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

    // Single write then single read of the same location.
    vt[0] = mk(1, 1, 0, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00);
    vt[1] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 2'b10, 2'b00, 8'h00);
    vt[2] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 2'b10, 8'hA5);
    // Four contended reads: 0 reads 0x10 (A5), 1 reads 0x20 (still 0).
`ifdef DRAM_ARB_RR_EN
    vt[3] = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b01, 2'b00, 8'h00);
    vt[4] = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b10, 2'b01, 8'hA5);
    vt[5] = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b01, 2'b10, 8'h00);
    vt[6] = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b10, 2'b01, 8'hA5);
    vt[7] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 2'b10, 8'h00);
`else
    vt[3] = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b01, 2'b00, 8'h00);
    vt[4] = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b01, 2'b01, 8'hA5);
    vt[5] = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b01, 2'b01, 8'hA5);
    vt[6] = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00, 2'b01, 2'b01, 8'hA5);
    vt[7] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 2'b01, 8'hA5);
`endif
    // Lock: requester 0 keeps ownership 3 cycles plus the unlocking cycle.
    vt[8]  = mk(1, 1, 1, 8'h30, 8'h11, 1, 1, 0, 8'h40, 8'h77, 2'b01, 2'b00, 8'h00);
    vt[9]  = mk(1, 1, 1, 8'h30, 8'h22, 1, 1, 0, 8'h40, 8'h77, 2'b01, 2'b00, 8'h00);
    vt[10] = mk(1, 1, 1, 8'h30, 8'h33, 1, 1, 0, 8'h40, 8'h77, 2'b01, 2'b00, 8'h00);
    vt[11] = mk(1, 1, 0, 8'h30, 8'h44, 1, 1, 0, 8'h40, 8'h77, 2'b01, 2'b00, 8'h00);
    vt[12] = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h40, 8'h77, 2'b10, 2'b00, 8'h00);
    // Write followed immediately by read of the same address.
    vt[13] = mk(1, 1, 0, 8'h55, 8'h3C, 0, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00);
    vt[14] = mk(1, 0, 0, 8'h55, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00);
    vt[15] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 2'b00, 2'b01, 8'h3C);

    // Reset state, with requests present to show grants are suppressed.
    rst_n = 1'b0;
    m_reset();
    set_in(1, 0, 1, 8'h01, 8'h00, 1, 1, 1, 8'h02, 8'h09);
    #12;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_en", {ram_w_en, ram_r_en}, 0);
    @(negedge clk);
    set_in(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      set_in(vt[i].r0, vt[i].w0, vt[i].l0, vt[i].a0, vt[i].d0,
             vt[i].r1, vt[i].w1, vt[i].l1, vt[i].a1, vt[i].d1);
      #1;
      chk($sformatf("vec%0d_gnt", i), {gnt1, gnt0}, vt[i].gnt);
      chk($sformatf("vec%0d_rvalid", i), {rvalid1, rvalid0}, vt[i].rv);
      if (vt[i].rv != 2'b00) chk($sformatf("vec%0d_rdata", i), rdata, vt[i].rd);
      cycle();
    end

    // Reset mid-lock with a read in flight.
    set_in(1, 0, 1, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    cycle();
    set_in(1, 0, 1, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("midrst_gnt", {gnt1, gnt0}, 0);
    chk("midrst_rvalid", {rvalid1, rvalid0}, 0);
    chk("midrst_r_en", ram_r_en, 0);
    @(posedge clk);
    #1;
    chk("midrst_rvalid_edge", {rvalid1, rvalid0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Ownership must be gone: requester 1 alone is served immediately.
    set_in(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00);
    #1;
    chk("postrst_rvalid", {rvalid1, rvalid0}, 0);
    chk("postrst_gnt", {gnt1, gnt0}, 2'b10);
    cycle();

    // Randomized traffic on a small address window to exercise hazards.
    for (int n = 0; n < 3000; n++) begin
      ra  = 8'($urandom_range(0, 15));
      rd0 = 8'($urandom_range(0, 15));
      set_in(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
             ($urandom_range(0, 9) < 3), ra, 8'($urandom),
             ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
             ($urandom_range(0, 9) < 3), rd0, 8'($urandom));
      cycle();
    end
    set_in(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_arb.md
DRAM_ARB -- requirements
Module: dram_arb

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width in bits.
REQ-002 Parameter DATA_W, default 8, RAM data width in bits.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req0, req1  in  1 each  access request from requester 0 and requester 1.
REQ-006 we0, we1  in  1 each  operation select per requester: 1 = write, 0 = read.
REQ-007 lock0, lock1  in  1 each  hold ownership after the current grant.
REQ-008 addr0, addr1  in  ADDR_W each  access address per requester.
REQ-009 wdata0, wdata1  in  DATA_W each  write data per requester.
REQ-010 gnt0, gnt1  out  1 each  combinational grant; the access issues in the cycle the grant is high.
REQ-011 rvalid0, rvalid1  out  1 each  read data valid, registered.
REQ-012 rdata  out  DATA_W  read data, passed straight through from ram_dout.
REQ-013 ram_w_en, ram_w_addr, ram_din  out  1/ADDR_W/DATA_W  drive the RAM write port.
REQ-014 ram_r_en, ram_r_addr  out  1/ADDR_W  drive the RAM read port.
REQ-015 ram_dout  in  DATA_W  RAM registered read data, valid one cycle after ram_r_en.

Function
REQ-016 At most one of gnt0/gnt1 is high in any cycle, and a grant is only given to a requester whose req is high.
REQ-017 The granted requester's we, addr and wdata are muxed onto the RAM ports in the same cycle.
REQ-018 ram_w_en is gnt&we; ram_r_en is gnt&~we; with no grant, ram_w_en=ram_r_en=0 and addresses/data are 0.
REQ-019 Read latency is 1: rvalidN is high exactly the cycle after a granted read by N, and rdata=ram_dout in that cycle.
REQ-020 rvalid is never high for a write, and never for the requester that was not granted.
REQ-021 FSM states are IDLE, OWN0 and OWN1. In IDLE, grants are chosen by the arbitration policy (REQ-027/028).
REQ-022 A grant to N with lockN=1 moves the FSM to OWNN.
REQ-023 In OWNN, N is granted whenever reqN=1 and the other requester is blocked.
REQ-024 The FSM leaves OWNN to IDLE after a granted cycle with lockN=0, or after any cycle with reqN=0.
REQ-025 Back-to-back accesses issue one per cycle with no bubble.
REQ-026 A write followed next cycle by a read to the same address returns the new data.

Configuration
REQ-027 With DRAM_ARB_RR_EN defined, IDLE arbitration is round-robin: a 1-bit last-grant register favours the requester not granted most recently on contention, and is updated on every grant.
REQ-028 Without DRAM_ARB_RR_EN, IDLE arbitration is fixed priority with requester 0 winning, and no last-grant register exists.

Reset
REQ-029 When rst_n is low: FSM=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, all RAM enables 0, last-grant=1 (requester 0 favoured first).
REQ-030 A reset asserted mid-lock or with a read in flight drops ownership, and the pending rvalid is not produced after reset release.
REQ-031 Grants are suppressed while rst_n is low, regardless of req.

Structure
REQ-032 The shared package dram_arb_pkg holds the FSM state enum (IDLE/OWN0/OWN1) and the default ADDR_W/DATA_W constants.
REQ-033 One sub-module, dram_arb_pick, is natural: a combinational two-way picker taking req and the favoured requester and returning a one-hot grant.
REQ-034 The RAM instance sits outside dram_arb and is wired at the SoC level.

Verification
REQ-035 Single write: req0=1, we0=1, addr0=0x10, wdata0=0xA5 for one cycle -> gnt0=1 the same cycle, ram_w_en=1, ram_w_addr=0x10, ram_din=0xA5.
REQ-036 Single read: next cycle req1=1, we1=0, addr1=0x10 -> gnt1=1, ram_r_en=1; the following cycle rvalid1=1, rdata=0xA5, rvalid0=0.
REQ-037 Contention with DRAM_ARB_RR_EN: req0=req1=1 held for 4 reads -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-038 Contention without the macro: req0=req1=1 held for 4 cycles -> gnt0 high all 4 cycles, gnt1 never high.
REQ-039 Lock: req0=1, lock0=1 for 3 cycles, then lock0=0 for 1 cycle, with req1=1 throughout -> gnt0 for 4 cycles, then gnt1.
REQ-040 Reset mid-read: read granted, rst_n=0 before the next edge -> rvalid0 and rvalid1 stay 0 and the FSM returns to IDLE.
